// File: rtl/syn_data_mem_banked.sv
// syn_data_mem_banked: byte-lane data memory with fixed-latency request/response handshake.
// Define DM_ALIGN_CHECK_EN to flag and suppress misaligned word/halfword accesses.
module syn_data_mem_banked #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] data_w,
  output logic        resp_valid,
  output logic [31:0] data_r,
  output logic        misalign,
  input  logic [31:0] addr_dbg,
  output logic [31:0] data_dbg
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] word, ld, rdat, wr, pend;
  logic [15:0] half;
  logic [7:0] bsel;
  logic [3:0] be;
  logic accept, store, mis, pend_mis, last, unused;

  assign idx = addr[ADDR_WIDTH+1:2];
  assign word = mem[idx];
  assign data_dbg = mem[addr_dbg[ADDR_WIDTH+1:2]];
  assign req_ready = en & (state == IDLE || state == RESP);
  assign resp_valid = en & (state == RESP);
  assign accept = req_valid & req_ready;
  assign store = op >= 3'd5;
  assign last = cnt == 4'(LATENCY - 1);
  assign unused = ^{addr[31:ADDR_WIDTH+2], addr_dbg[31:ADDR_WIDTH+2], addr_dbg[1:0]};

`ifdef DM_ALIGN_CHECK_EN
  assign mis = ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'b00) ||
               ((op == 3'd1 || op == 3'd2 || op == 3'd6) && addr[0]);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    half = addr[1] ? word[31:16] : word[15:0];
    bsel = word[{addr[1:0], 3'b000} +: 8];
    ld = mis ? 32'd0 :
         op == 3'd0 ? word :
         op == 3'd1 ? {{16{half[15]}}, half} :
         op == 3'd2 ? {16'd0, half} :
         op == 3'd3 ? {{24{bsel[7]}}, bsel} :
         op == 3'd4 ? {24'd0, bsel} : 32'd0;
    rdat = store ? 32'd0 : ld;
    be = op == 3'd5 ? 4'hf :
         op == 3'd6 ? (addr[1] ? 4'hc : 4'h3) :
         op == 3'd7 ? 4'b0001 << addr[1:0] : 4'h0;
    wr = op == 3'd5 ? data_w : op == 3'd6 ? {2{data_w[15:0]}} : {4{data_w[7:0]}};
    state_nx = !en ? state :
               accept ? (LATENCY == 1 ? RESP : WAIT) :
               state == WAIT ? (last ? RESP : WAIT) : IDLE;
    cnt_nx = !en ? cnt : (state == WAIT && !last) ? cnt + 4'd1 : 4'd0;
  end

  // Memory has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk)
    if (rst_n && accept && store && !mis)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wr[8*i +: 8];

  // Load data is captured at acceptance and published when the response starts.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      data_r <= 32'd0;
      misalign <= 1'b0;
      pend <= 32'd0;
      pend_mis <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        pend <= rdat;
        pend_mis <= mis;
      end
      if (en && state_nx == RESP) begin
        data_r <= accept ? rdat : pend;
        misalign <= accept ? mis : pend_mis;
      end
    end
endmodule

// File: doc/syn_data_mem_banked.md
SYN_DATA_MEM_BANKED -- requirements
Module: syn_data_mem_banked

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set word-address bits; depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 1, legal 1..15, SHALL set the number of clock edges from request acceptance to the response.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 en  in  1  global enable; 0 = stall.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 op  in  3  access type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-009 addr  in  32  byte address.
REQ-010 data_w  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle response strobe.
REQ-012 data_r  out  32  load result, extended to 32 bits.
REQ-013 misalign  out  1  misaligned-access flag, valid with resp_valid.
REQ-014 addr_dbg  in  32  debug byte address.
REQ-015 data_dbg  out  32  debug word, combinational read.

Function
REQ-016 Request SHALL be accepted on a rising edge where en=1, req_valid=1 and req_ready=1; op, addr and data_w are sampled at that edge.
REQ-017 FSM states IDLE, WAIT, RESP; IDLE->WAIT on accept if LATENCY>1, IDLE->RESP on accept if LATENCY=1; WAIT->RESP when the latency counter reaches LATENCY-1; RESP->IDLE without accept, RESP->WAIT/RESP on accept.
REQ-018 req_ready SHALL equal en AND (state is IDLE or RESP); back-to-back requests are accepted during the RESP cycle.
REQ-019 resp_valid SHALL be high for exactly one enabled cycle, starting LATENCY edges after the accepting edge, and SHALL equal en AND (state is RESP).
REQ-020 en=0 SHALL freeze state, counter, data_r and memory; no write occurs; a pending response reappears when en returns to 1.
REQ-021 Word index SHALL be addr[ADDR_WIDTH+1:2]; higher address bits are ignored (wrap-around).
REQ-022 Stores SHALL commit at the accepting edge, little-endian: SW all four lanes; SH data_w[15:0] into lanes selected by addr[1]; SB data_w[7:0] into lane addr[1:0]; other lanes unchanged.
REQ-023 Loads SHALL read the array at the accepting edge into data_r: LW word; LH/LHU halfword by addr[1], sign/zero-extended; LB/LBU byte by addr[1:0], sign/zero-extended.
REQ-024 A load accepted in the same edge as, or after, a store to the same word SHALL return post-store data.
REQ-025 data_r SHALL hold its value until the next load response; store responses set data_r to 0.
REQ-026 data_dbg SHALL be the current word at addr_dbg[ADDR_WIDTH+1:2], independent of en and FSM state.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, data_r 0, misalign 0, resp_valid 0; req_ready = en after release.
REQ-028 Reset SHALL NOT alter memory contents; reset mid-WAIT SHALL drop the response; a store already accepted remains committed.

Configuration
REQ-029 Macro DM_ALIGN_CHECK_EN defined: LW/SW with addr[1:0]!=0 or LH/LHU/SH with addr[0]=1 SHALL set misalign=1 with its resp_valid, suppress the store, and return data_r=0.
REQ-030 Macro DM_ALIGN_CHECK_EN undefined: misalign SHALL be tied 0; addr[1:0] ignored for words and addr[0] ignored for halfwords.

Verification
REQ-031 LATENCY=1: SW 0xDEADBEEF to 0x10 then LW 0x10 back-to-back -> resp_valid in cycles 1 and 2, data_r=0xDEADBEEF on second response, req_ready never low.
REQ-032 LATENCY=4: LW accepted at edge 0 -> resp_valid high only in cycle after edge 4, req_ready low in cycles 1-3.
REQ-033 SB 0x80 to 0x23 over word 0 at 0x20 -> LB 0x23 gives 0xFFFFFF80, LBU gives 0x00000080, LW 0x20 gives 0x80000000, data_dbg at 0x20 = 0x80000000.
REQ-034 With DM_ALIGN_CHECK_EN: SW to 0x22 -> misalign=1, data_dbg at 0x20 unchanged; without macro: write lands at word 0x20, misalign=0.
REQ-035 en=0 for 3 cycles while in RESP -> resp_valid 0 during stall, then one pulse after en=1; rst_n pulse during WAIT -> no response, state IDLE, data_r=0.
REQ-036 ADDR_WIDTH=4: SW to 0x40 -> readable at 0x00 (wrap-around).
